// File: rtl/booth_mult_seq.sv
// Sequential radix-4 (modified) Booth multiplier.
// One Booth digit is retired per clock. Signed and unsigned operation is
// selectable per request. The full 2*WIDTH-bit product is presented as hi/lo.
//
// Handshake: start is sampled on a rising edge only while busy=0 (IDLE or
// DONE state). A sampled start latches is_signed and both operands.
// busy stays high for the N iteration cycles. done is a one-cycle pulse that
// is registered together with hi/lo, so hi/lo are valid whenever done=1.
// hi/lo then hold that value until the next done.
module booth_mult_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH / 2 + 2)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [1:0]       state_dbg
);

  // Operands are widened by two bits so that unsigned values stay positive.
  // This also makes the number of Booth digits a whole number.
  localparam int EW = WIDTH + 2;
  // The accumulator carries guard bits so that +/-2M cannot overflow.
  localparam int AW = WIDTH + 4;
  localparam int PW = AW + EW;
  localparam logic [CNT_W-1:0] NDIG = CNT_W'((WIDTH + 2) / 2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             load;
  logic             step;
  logic [CNT_W-1:0] count;
  logic [AW-1:0]    acc;
  logic [AW-1:0]    mcand;
  logic [EW-1:0]    q;
  logic             q_m1;

  logic [AW-1:0]    m_ext;
  logic [EW-1:0]    q_ext;
  logic [AW-1:0]    pp;
  logic [AW-1:0]    sum;
  logic [AW-1:0]    acc_nxt;
  logic [EW-1:0]    q_nxt;
  logic [PW-1:0]    prod;
  logic             prod_unused;

  assign state_dbg = state;

  // State register. Reset is asynchronous and returns the FSM to IDLE.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic, load/step enables and busy.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    busy      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = CALC;
        end
      end
      CALC: begin
        busy = 1'b1;
        step = 1'b1;
        if (count == CNT_W'(1)) state_nxt = DONE;
      end
      DONE: begin
        // hi/lo are captured on the edge that ends this cycle.
        // A start sampled on that same edge begins the next operation.
        if (start) begin
          load      = 1'b1;
          state_nxt = CALC;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand extension. Sign bits are used only in signed mode.
  always_comb begin
    m_ext = {{4{is_signed & multiplicand[WIDTH-1]}}, multiplicand};
    q_ext = {{2{is_signed & multiplier[WIDTH-1]}}, multiplier};
  end

  // Booth recoding of {q[1], q[0], q[-1]}, accumulate, then a 2-bit arithmetic shift.
  always_comb begin
    pp = '0;
    unique case ({q[1:0], q_m1})
      3'b000, 3'b111: pp = '0;
      3'b001, 3'b010: pp = mcand;
      3'b011:         pp = mcand << 1;
      3'b100:         pp = -(mcand << 1);
      3'b101, 3'b110: pp = -mcand;
      default:        pp = '0;
    endcase
    sum     = acc + pp;
    acc_nxt = {{2{sum[AW-1]}}, sum[AW-1:2]};
    q_nxt   = {sum[1:0], q[EW-1:2]};
  end

  // Iteration datapath: latch operands on load, retire one digit per step.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      acc   <= '0;
      mcand <= '0;
      q     <= '0;
      q_m1  <= 1'b0;
      count <= '0;
    end else if (load) begin
      acc   <= '0;
      mcand <= m_ext;
      q     <= q_ext;
      q_m1  <= 1'b0;
      count <= NDIG;
    end else if (step) begin
      acc   <= acc_nxt;
      q     <= q_nxt;
      q_m1  <= q[1];
      count <= count - CNT_W'(1);
    end
  end

  // After N double-shifts, q holds the low product bits and acc holds the rest.
  assign prod        = {acc, q};
  assign prod_unused = ^prod[PW-1:2*WIDTH];

  // Result registers and done pulse. Both are updated on the edge that leaves DONE.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      done <= 1'b0;
      hi   <= '0;
      lo   <= '0;
    end else begin
      done <= (state == DONE);
      if (state == DONE) begin
        hi <= prod[2*WIDTH-1:WIDTH];
        lo <= prod[WIDTH-1:0];
      end
    end
  end

endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed-vector bench for booth_mult_seq (WIDTH=32) with a scoreboard queue.
module tb_booth_mult_seq;

  logic        clk;
  logic        clr;
  logic        start;
  logic        is_signed;
  logic [31:0] multiplicand;
  logic [31:0] multiplier;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [1:0]  state_dbg;

  logic [63:0] exp_q[$];
  int          n_cmp;
  int          n_bad;
  int          done_cnt;

  booth_mult_seq #(.WIDTH(32)) dut (
    .clk          (clk),
    .clr          (clr),
    .start        (start),
    .is_signed    (is_signed),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .hi           (hi),
    .lo           (lo),
    .state_dbg    (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Driver: the caller is at a negedge. Start is held for exactly one rising edge.
  task automatic issue(input logic sgn, input logic [31:0] m, input logic [31:0] q,
                       input logic [63:0] exp, input bit push);
    is_signed    = sgn;
    multiplicand = m;
    multiplier   = q;
    start        = 1'b1;
    if (push) exp_q.push_back(exp);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at the negedge following the start edge.
  // Returns the number of cycles to done and the number of cycles busy was high.
  task automatic wait_done(output int n, output int busy_n);
    n = 0;
    busy_n = busy ? 1 : 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
      if (busy) busy_n++;
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_timeout: no done after %0d cycles, expected one", n);
    end
  endtask

  // Monitor / scoreboard: every done pulse pops one expected product.
  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got product %h, expected no done", {hi, lo});
      end else begin
        check("product", {hi, lo}, exp_q.pop_front());
      end
    end
  end

  // Directed vectors with hand-computed products.
  logic        v_s [10];
  logic [31:0] v_m [10];
  logic [31:0] v_q [10];
  logic [63:0] v_p [10];

  initial begin
    v_s[0] = 1'b1; v_m[0] = 32'hFFFF_FFF9; v_q[0] = 32'h0000_0003; v_p[0] = 64'hFFFF_FFFF_FFFF_FFEB;
    v_s[1] = 1'b0; v_m[1] = 32'hFFFF_FFFF; v_q[1] = 32'hFFFF_FFFF; v_p[1] = 64'hFFFF_FFFE_0000_0001;
    v_s[2] = 1'b1; v_m[2] = 32'hFFFF_FFFF; v_q[2] = 32'hFFFF_FFFF; v_p[2] = 64'h0000_0000_0000_0001;
    v_s[3] = 1'b1; v_m[3] = 32'h8000_0000; v_q[3] = 32'h8000_0000; v_p[3] = 64'h4000_0000_0000_0000;
    v_s[4] = 1'b1; v_m[4] = 32'h8000_0000; v_q[4] = 32'hFFFF_FFFF; v_p[4] = 64'h0000_0000_8000_0000;
    v_s[5] = 1'b0; v_m[5] = 32'h8000_0000; v_q[5] = 32'h0000_0002; v_p[5] = 64'h0000_0001_0000_0000;
    v_s[6] = 1'b1; v_m[6] = 32'h7FFF_FFFF; v_q[6] = 32'h7FFF_FFFF; v_p[6] = 64'h3FFF_FFFF_0000_0001;
    v_s[7] = 1'b0; v_m[7] = 32'h0000_0000; v_q[7] = 32'hFFFF_FFFF; v_p[7] = 64'h0000_0000_0000_0000;
    v_s[8] = 1'b1; v_m[8] = 32'hFFFF_FFFF; v_q[8] = 32'h0000_0002; v_p[8] = 64'hFFFF_FFFF_FFFF_FFFE;
    v_s[9] = 1'b0; v_m[9] = 32'hFFFF_FFFF; v_q[9] = 32'h0000_0002; v_p[9] = 64'h0000_0001_FFFF_FFFE;
  end

  initial begin
    int n;
    int bn;
    int dc0;
    n_cmp = 0;
    n_bad = 0;
    done_cnt = 0;
    clr = 1'b0;
    start = 1'b0;
    is_signed = 1'b0;
    multiplicand = '0;
    multiplier = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_hilo", {hi, lo}, 64'd0);
    check("reset_state", 64'(state_dbg), 64'd0);
    clr = 1'b1;
    @(negedge clk);

    // Directed table: latency and busy length are checked on every vector.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      issue(v_s[i], v_m[i], v_q[i], v_p[i], 1'b1);
      wait_done(n, bn);
      check("latency", 64'(n), 64'd18);
      if (i == 0) check("busy_cycles", 64'(bn), 64'd17);
    end

    // Start while busy must be ignored.
    @(negedge clk);
    dc0 = done_cnt;
    issue(1'b0, 32'd12, 32'd5, 64'd60, 1'b1);
    repeat (5) @(negedge clk);
    is_signed = 1'b1;
    multiplicand = 32'd9;
    multiplier = 32'd9;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    multiplicand = 32'hDEAD_BEEF;
    repeat (30) @(negedge clk);
    check("busy_prot_pulses", 64'(done_cnt - dc0), 64'd1);
    check("hold_hilo", {hi, lo}, 64'd60);

    // Back-to-back: the second start is sampled on the edge that leaves DONE.
    @(negedge clk);
    issue(1'b0, 32'h10, 32'h10, 64'h100, 1'b1);
    n = 0;
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    issue(1'b1, 32'd100, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FED4, 1'b1);
    check("b2b_first_done", 64'(done), 64'd1);
    check("b2b_restart_busy", 64'(busy), 64'd1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 40);
    check("b2b_gap", 64'(n), 64'd18);

    // Reset in the middle of CALC aborts the operation without a done pulse.
    @(negedge clk);
    dc0 = done_cnt;
    issue(1'b0, 32'd6, 32'd6, 64'd36, 1'b0);
    repeat (7) @(negedge clk);
    clr = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    clr = 1'b1;
    repeat (25) @(negedge clk);
    check("abort_no_done", 64'(done_cnt - dc0), 64'd0);
    issue(1'b0, 32'd6, 32'd7, 64'd42, 1'b1);
    wait_done(n, bn);
    check("post_reset_latency", 64'(n), 64'd18);

    repeat (3) @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
